// File: rtl/clk_edge_meter.sv
// -----------------------------------------------------------------------------
// clk_edge_meter
// Measures an external (asynchronous) clock against clk_i. The external clock
// is synchronized, edge strobes are derived from it, and every rising edge
// closes a measurement of period and high time, both counted in clk_i cycles.
// When no edge is seen for TIMEOUT cycles, loss of clock is flagged until the
// next rising edge restarts the measurement.
//
// Ports
//   clk_i      system clock, all logic on its rising edge
//   arst_ni    asynchronous active-low reset
//   clk_ext_i  clock under measurement, asynchronous to clk_i
//   clk_o      synchronized level of clk_ext_i
//   posedge_o  one-cycle strobe per detected rising edge
//   negedge_o  one-cycle strobe per detected falling edge
//   period_o   last measured period (saturates at 2^CNT_W-1)
//   high_o     last measured high time
//   valid_o    one-cycle strobe when period_o/high_o/ovf_o update
//   ovf_o      reported period saturated
//   lost_o     level, loss of clock
// -----------------------------------------------------------------------------
module clk_edge_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             clk_ext_i,
  output logic             clk_o,
  output logic             posedge_o,
  output logic             negedge_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             lost_o
);

  // Idle counter only needs to reach TIMEOUT-1: the timeout fires on the
  // cycle that would bring it to TIMEOUT.
  localparam int                IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2,
    S_LOST  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                hist_q;
  logic                pos_q, neg_q;
  logic                pos_d, neg_d, strobe_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                sat_q;
  logic [CNT_W-1:0]    high_cap_q;
  logic [IDLE_W-1:0]   idle_q;
  logic                timeout_d;
  logic                valid_d;
  logic                valid_q;
  logic [CNT_W-1:0]    period_q, high_q;
  logic                ovf_q;

  // Edge detection is done on the next-state side so the measurement
  // registers and the FSM update on the same edge that raises the strobe.
  assign pos_d    =  sync_q[SYNC_STAGES-1] & ~hist_q;
  assign neg_d    = ~sync_q[SYNC_STAGES-1] &  hist_q;
  assign strobe_d = pos_d | neg_d;

  // An edge in the same cycle as the timeout wins.
  assign timeout_d = ~strobe_d & (idle_q == IDLE_LAST);

  // Synchronizer, history flop and registered strobes.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_ext_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  // Period counter runs freely between rising edges; it restarts at 1 so the
  // value read on the next rising edge equals the full period.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      high_cap_q <= '0;
    end else begin
      if (pos_d) begin
        cnt_q <= CNT_W'(1);
        sat_q <= 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (neg_d) begin
        high_cap_q <= cnt_q;
      end
    end
  end

  // Idle counter, cleared by either edge, parks at its last value.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      idle_q <= '0;
    end else if (strobe_d) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  // Reported measurement, held between valid pulses and while lost.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      valid_q  <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) begin
        period_q <= cnt_q;
        high_q   <= high_cap_q;
        ovf_q    <= sat_q;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (pos_d) begin
      case (state_q)
        S_WAIT:  state_d = S_FIRST;
        S_FIRST: state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        S_LOST:  state_d = S_FIRST;
        default: state_d = S_WAIT;
      endcase
    end else if (timeout_d) begin
      state_d = S_LOST;
    end
  end

  // FSM: outputs. A rising edge only closes a measurement once a previous
  // rising edge has opened it.
  always_comb begin
    valid_d = pos_d & ((state_q == S_FIRST) | (state_q == S_RUN));
    lost_o  = (state_q == S_LOST);
  end

  assign clk_o     = sync_q[SYNC_STAGES-1];
  assign posedge_o = pos_q;
  assign negedge_o = neg_q;
  assign valid_o   = valid_q;
  assign period_o  = period_q;
  assign high_o    = high_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_clk_edge_meter.sv
module tb_clk_edge_meter;

  localparam int CW = 8;
  localparam int TO = 64;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic arst_ni = 1'b0;
  logic clk_ext_i = 1'b0;

  logic          clk_o, posedge_o, negedge_o, valid_o, ovf_o, lost_o;
  logic [CW-1:0] period_o, high_o;
  logic          b_clk_o, b_posedge_o, b_negedge_o, b_valid_o, b_ovf_o, b_lost_o;
  logic [CW-1:0] b_period_o, b_high_o;

  clk_edge_meter #(.SYNC_STAGES(2), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .clk_ext_i(clk_ext_i),
    .clk_o(clk_o), .posedge_o(posedge_o), .negedge_o(negedge_o),
    .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
    .ovf_o(ovf_o), .lost_o(lost_o)
  );

  // Long-timeout instance: a 300-cycle period with 150-cycle phases cannot
  // be measured with TIMEOUT=64, so saturation is observed here.
  clk_edge_meter #(.SYNC_STAGES(2), .CNT_W(CW), .TIMEOUT(1024)) dut_b (
    .clk_i(clk), .arst_ni(arst_ni), .clk_ext_i(clk_ext_i),
    .clk_o(b_clk_o), .posedge_o(b_posedge_o), .negedge_o(b_negedge_o),
    .period_o(b_period_o), .high_o(b_high_o), .valid_o(b_valid_o),
    .ovf_o(b_ovf_o), .lost_o(b_lost_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on the list of clk_ext_i samples and on cycle
  // numbers of detected edges. A level sampled on edge n shows as clk_o after
  // edge n+1 and as a strobe after edge n+2. Measurements are differences of
  // rising-edge cycle numbers; loss is 64 cycles since the last strobe.
  // ---------------------------------------------------------------------------
  bit samp[$];
  int n, last_pos, last_strobe, rises, high_m;
  bit lost_m;
  bit e_clk, e_pos, e_neg, e_valid, e_lost, e_ovf;
  int e_period, e_high;

  task automatic model_reset();
    samp.delete();
    repeat (4) samp.push_back(1'b0);
    n = 0; last_pos = 0; last_strobe = 0; rises = 0; high_m = 0; lost_m = 1'b0;
    e_clk = 0; e_pos = 0; e_neg = 0; e_valid = 0; e_lost = 0; e_ovf = 0;
    e_period = 0; e_high = 0;
  endtask

  task automatic model_step();
    int p;
    n++;
    samp.push_front(clk_ext_i);
    if (samp.size() > 4) void'(samp.pop_back());
    e_clk = samp[1];
    e_pos = samp[2] && !samp[3];
    e_neg = !samp[2] && samp[3];
    e_valid = 1'b0;
    if (e_neg) begin
      p = n - last_pos;
      high_m = (p > MAXV) ? MAXV : p;
    end
    if (e_pos) begin
      if (rises >= 1) begin
        p = n - last_pos;
        e_valid  = 1'b1;
        e_period = (p > MAXV) ? MAXV : p;
        e_ovf    = (p > MAXV);
        e_high   = high_m;
      end
      rises = 1 + ((rises >= 1) ? 1 : 0);
      last_pos = n;
      lost_m = 1'b0;
    end
    if (e_pos || e_neg) last_strobe = n;
    else if (n - last_strobe >= TO) begin
      lost_m = 1'b1;
      rises = 0;
    end
    e_lost = lost_m;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge arst_ni);
      if (!arst_ni) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("clk_o", clk_o, e_clk);
        check("posedge_o", posedge_o, e_pos);
        check("negedge_o", negedge_o, e_neg);
        check("valid_o", valid_o, e_valid);
        check("lost_o", lost_o, e_lost);
        check("period_o", period_o, e_period);
        check("high_o", high_o, e_high);
        check("ovf_o", ovf_o, e_ovf);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  task automatic run_wave(input int per, input int hi, input int cyc, output int fv);
    int npos;
    npos = 0;
    fv = 0;
    for (int k = 0; k < per * cyc; k++) begin
      @(negedge clk);
      if (posedge_o) begin
        npos++;
        if (valid_o && fv == 0) fv = npos;
      end
      clk_ext_i = ((k % per) < hi);
    end
  endtask

  task automatic wait_strobe(input bit want_pos, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (want_pos ? posedge_o : negedge_o) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk_o"}, clk_o, 0);
    check({tag, "_posedge_o"}, posedge_o, 0);
    check({tag, "_negedge_o"}, negedge_o, 0);
    check({tag, "_valid_o"}, valid_o, 0);
    check({tag, "_lost_o"}, lost_o, 0);
    check({tag, "_period_o"}, period_o, 0);
    check({tag, "_high_o"}, high_o, 0);
    check({tag, "_ovf_o"}, ovf_o, 0);
  endtask

  initial begin
    int fv, gap, last, first_clk, first_pos, pos_cycles;
    bit lost_seen;

    arst_ni = 1'b0;
    clk_ext_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_all_zero("reset");
    arst_ni = 1'b1;

    // Square wave 10/4: first rise gives no valid, later rises report 10/4.
    run_wave(10, 4, 6, fv);
    check("sq_first_valid_rise", fv, 2);
    check("sq_period", period_o, 10);
    check("sq_high", high_o, 4);
    check("sq_ovf", ovf_o, 0);
    $display("square 10/4: period=%0d high=%0d ovf=%0d first_valid_rise=%0d", period_o, high_o, ovf_o, fv);

    // Single rise: clk_o on the 2nd edge, strobe on the 3rd, one cycle wide.
    repeat (5) @(negedge clk);
    clk_ext_i = 1'b1;
    first_clk = 0; first_pos = 0; pos_cycles = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (clk_o && first_clk == 0) first_clk = i;
      if (posedge_o) begin
        pos_cycles++;
        if (first_pos == 0) first_pos = i;
      end
    end
    check("rise_clk_o_edge", first_clk, 2);
    check("rise_strobe_edge", first_pos, 3);
    check("rise_strobe_width", pos_cycles, 1);
    $display("single rise: clk_o at edge %0d, posedge_o at edge %0d, width %0d", first_clk, first_pos, pos_cycles);

    // Long period on the long-timeout instance: saturates.
    run_wave(300, 150, 3, fv);
    check("sat_period", b_period_o, MAXV);
    check("sat_ovf", b_ovf_o, 1);
    check("sat_high", b_high_o, 150);
    check("sat_lost", b_lost_o, 0);
    $display("period 300/150: period=%0d high=%0d ovf=%0d", b_period_o, b_high_o, b_ovf_o);

    // Frozen input: lost exactly 64 cycles after the last strobe.
    run_wave(10, 4, 2, fv);
    clk_ext_i = 1'b1;
    repeat (4) @(negedge clk);
    clk_ext_i = 1'b0;
    last = 0; gap = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (posedge_o || negedge_o) last = i;
      if (lost_o) begin
        gap = i - last;
        break;
      end
    end
    check("lost_gap", gap, TO);
    $display("loss: lost_o after %0d idle cycles", gap);
    clk_ext_i = 1'b1;
    wait_strobe(1'b1, "relock_rise1_seen");
    check("relock_rise1_valid", valid_o, 0);
    check("relock_rise1_lost", lost_o, 0);
    @(negedge clk);
    clk_ext_i = 1'b0;
    repeat (6) @(negedge clk);
    clk_ext_i = 1'b1;
    wait_strobe(1'b1, "relock_rise2_seen");
    check("relock_rise2_valid", valid_o, 1);
    check("relock_rise2_lost", lost_o, 0);
    check("relock_period", period_o, 10);
    check("relock_high", high_o, 4);
    $display("relock: valid=%0d period=%0d high=%0d lost=%0d", valid_o, period_o, high_o, lost_o);

    // Edge strobe in the very cycle the idle count reaches 64.
    @(negedge clk);
    clk_ext_i = 1'b0;
    wait_strobe(1'b0, "edge_at_to_fall_seen");
    lost_seen = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      @(negedge clk);
      if (lost_o) lost_seen = 1'b1;
    end
    clk_ext_i = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (lost_o) lost_seen = 1'b1;
    end
    check("edge_at_to_strobe", posedge_o, 1);
    check("edge_at_to_no_lost", lost_seen, 0);
    $display("edge at timeout: posedge_o=%0d lost_seen=%0d", posedge_o, lost_seen);

    // One cycle later than that: loss is declared, next rise has no valid.
    @(negedge clk);
    clk_ext_i = 1'b0;
    wait_strobe(1'b0, "edge_late_fall_seen");
    for (int i = 1; i <= 62; i++) @(negedge clk);
    clk_ext_i = 1'b1;
    @(negedge clk);
    check("edge_late_lost_63", lost_o, 0);
    @(negedge clk);
    check("edge_late_lost_64", lost_o, 1);
    @(negedge clk);
    check("edge_late_strobe", posedge_o, 1);
    check("edge_late_valid", valid_o, 0);
    check("edge_late_lost_65", lost_o, 0);
    $display("edge one cycle late: posedge_o=%0d valid_o=%0d lost_o=%0d", posedge_o, valid_o, lost_o);

    // Reset mid-period: outputs clear at once, restart needs two rises.
    run_wave(10, 4, 2, fv);
    @(negedge clk);
    clk_ext_i = 1'b1;
    repeat (2) @(negedge clk);
    #3 arst_ni = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    arst_ni = 1'b1;
    run_wave(10, 4, 4, fv);
    check("midrst_first_valid_rise", fv, 2);
    check("midrst_period", period_o, 10);
    check("midrst_high", high_o, 4);
    $display("mid-period reset: first_valid_rise=%0d period=%0d high=%0d", fv, period_o, high_o);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
